// File: rtl/fp32_stream_accum.sv
// rtl/fp32_stream_accum.sv - handshaked FP32 group accumulator with its combinational FP32 adder
// Optional output clamp of negative results to +0 when FP_ACCUM_RELU_EN is defined.

module fp32_add (
  input  logic        i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_sum
);
  logic [31:0] w_b, w_big, w_sml;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_sub, w_found, w_rnd;
  logic [7:0]  w_e_big, w_e_sml, w_d;
  logic [26:0] w_m_big, w_m_sml, w_m_sh, w_norm;
  logic [27:0] w_sum;
  logic [9:0]  w_e;
  logic [4:0]  w_lz, w_sh;
  logic [24:0] w_mant;

  assign w_b = {i_b[31] ^ i_op, i_b[30:0]};

  always_comb begin
    w_a_nan = (&i_a[30:23]) && (|i_a[22:0]);
    w_b_nan = (&w_b[30:23]) && (|w_b[22:0]);
    w_a_inf = (&i_a[30:23]) && !(|i_a[22:0]);
    w_b_inf = (&w_b[30:23]) && !(|w_b[22:0]);
    w_big   = (w_b[30:0] > i_a[30:0]) ? w_b : i_a;
    w_sml   = (w_b[30:0] > i_a[30:0]) ? i_a : w_b;
    w_sub   = w_big[31] ^ w_sml[31];
    // Denormals carry a zero hidden bit and the same scale as exponent 1.
    w_e_big = (w_big[30:23] == 8'd0) ? 8'd1 : w_big[30:23];
    w_e_sml = (w_sml[30:23] == 8'd0) ? 8'd1 : w_sml[30:23];
    w_m_big = {|w_big[30:23], w_big[22:0], 3'b000};
    w_m_sml = {|w_sml[30:23], w_sml[22:0], 3'b000};
    w_d     = w_e_big - w_e_sml;
    if (w_d >= 8'd27) begin
      w_m_sh = {26'd0, |w_m_sml};
    end else begin
      w_m_sh = (w_m_sml >> w_d) | {26'd0, |(w_m_sml & ~({27{1'b1}} << w_d))};
    end
    w_sum = w_sub ? ({1'b0, w_m_big} - {1'b0, w_m_sh}) : ({1'b0, w_m_big} + {1'b0, w_m_sh});
    w_e   = {2'b00, w_e_big};
    w_lz    = 5'd27;
    w_found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!w_found && w_sum[i]) begin
        w_found = 1'b1;
        w_lz    = 5'(26 - i);
      end
    end
    w_sh   = 5'd0;
    w_norm = w_sum[26:0];
    if (w_sum[27]) begin
      w_norm = {w_sum[27:2], w_sum[1] | w_sum[0]};
      w_e    = w_e + 10'd1;
    end else begin
      // Left normalisation stops at exponent 1 so small results become denormal.
      if ({5'd0, w_lz} <= w_e - 10'd1) w_sh = w_lz;
      else                             w_sh = 5'(w_e - 10'd1);
      w_norm = w_sum[26:0] << w_sh;
      w_e    = w_e - {5'd0, w_sh};
    end
    w_rnd  = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_mant = {1'b0, w_norm[26:3]} + {24'd0, w_rnd};
    if (w_mant[24]) begin
      w_mant = w_mant >> 1;
      w_e    = w_e + 10'd1;
    end
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (i_a[31] != w_b[31]))) begin
      o_sum = 32'h7FC00000;
    end else if (w_a_inf) begin
      o_sum = i_a;
    end else if (w_b_inf) begin
      o_sum = w_b;
    end else if (w_sum == 28'd0) begin
      o_sum = {w_sub ? 1'b0 : w_big[31], 31'd0};
    end else if (w_e >= 10'd255) begin
      o_sum = {w_big[31], 8'hFF, 23'd0};
    end else begin
      o_sum = {w_big[31], w_mant[23] ? w_e[7:0] : 8'd0, w_mant[22:0]};
    end
  end
endmodule

module fp32_stream_accum #(
  parameter int MAX_TERMS = 9,
  parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_cfg_terms,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [31:0]      i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [31:0]      o_out_data,
  output logic [CNT_W-1:0] o_term_cnt,
  output logic             o_busy
);
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  state_t           r_state, w_state_n;
  logic [31:0]      r_acc, w_sum;
  logic [CNT_W-1:0] r_cnt, r_len, w_len, w_cnt_inc;
  logic             w_accept;

  localparam logic [CNT_W-1:0] LP_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_TERMS);

  fp32_add u_add (
    .i_op  (1'b0),
    .i_a   (r_acc),
    .i_b   (i_in_data),
    .o_sum (w_sum)
  );

  assign w_cnt_inc = r_cnt + LP_ONE;

  always_comb begin
    w_len = i_cfg_terms;
    if (i_cfg_terms == '0)         w_len = LP_ONE;
    else if (i_cfg_terms > LP_MAX) w_len = LP_MAX;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_n;
  end

  always_comb begin
    w_state_n   = r_state;
    o_in_ready  = i_rst_n && (r_state != S_HOLD);
    o_out_valid = (r_state == S_HOLD);
    o_busy      = (r_state != S_IDLE);
    w_accept    = i_in_valid && o_in_ready && !i_clear;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_n = (w_len == LP_ONE) ? S_HOLD : S_ACCUM;
      end
      S_ACCUM: begin
        if (i_clear)                              w_state_n = S_IDLE;
        else if (w_accept && w_cnt_inc == r_len)  w_state_n = S_HOLD;
      end
      S_HOLD: begin
        if (i_out_ready) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= 32'h0;
      r_cnt <= '0;
      r_len <= LP_ONE;
    end else if (r_state == S_HOLD) begin
      if (i_out_ready) r_cnt <= '0;
    end else if (i_clear) begin
      r_acc <= 32'h0;
      r_cnt <= '0;
    end else if (w_accept) begin
      if (r_state == S_IDLE) begin
        // First term loads directly so a lone -0 survives.
        r_len <= w_len;
        r_acc <= i_in_data;
        r_cnt <= LP_ONE;
      end else begin
        r_acc <= w_sum;
        r_cnt <= w_cnt_inc;
      end
    end
  end

`ifdef FP_ACCUM_RELU_EN
  assign o_out_data = (r_acc[31] && r_acc != 32'h80000000) ? 32'h00000000 : r_acc;
`else
  assign o_out_data = r_acc;
`endif

  assign o_term_cnt = r_cnt;
endmodule

// File: tb/tb_fp32_stream_accum.sv
// tb/tb_fp32_stream_accum.sv - scoreboard bench for fp32_stream_accum
module tb_fp32_stream_accum;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic [CW-1:0] cfg_terms = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_data = 32'h0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_data;
  logic [CW-1:0] term_cnt;
  logic          busy;

  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  fp32_stream_accum dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_clear     (clear),
    .i_cfg_terms (cfg_terms),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_term_cnt  (term_cnt),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %h expected none", out_data);
        end else begin
          chk("out_data", out_data, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  endtask

  task automatic send(input logic [31:0] d);
    bit got = 0;
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!got && n < 50) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept of %h", d);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    fork
      monitor();
    join_none
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_term_cnt", {28'd0, term_cnt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    rst_n = 1'b1;
    cycle();
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // nine 1.0 back to back
    cfg_terms = 4'd9;
    exp_q.push_back(32'h41100000);
    for (int i = 0; i < 9; i++) begin
      send(32'h3F800000);
      if (i == 7) chk("pre_last_valid", {31'd0, out_valid}, 32'd0);
    end
    chk("hold_valid", {31'd0, out_valid}, 32'd1);
    chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    cycle();
    chk("next_group_ready", {31'd0, in_ready}, 32'd1);

    // backpressure
    cfg_terms = 4'd2;
    out_ready = 1'b0;
    exp_q.push_back(32'h40400000);
    send(32'h3F800000);
    send(32'h40000000);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 32'h42000000;
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    chk("bp_drained_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_term_cnt", {28'd0, term_cnt}, 32'd0);
    chk("bp_busy", {31'd0, busy}, 32'd0);

    // asynchronous reset mid-group
    cfg_terms = 4'd9;
    for (int i = 0; i < 4; i++) send(32'h3F800000);
    chk("pre_rst_cnt", {28'd0, term_cnt}, 32'd4);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_cnt", {28'd0, term_cnt}, 32'd0);
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    #9 rst_n = 1'b1;
    cycle();
    exp_q.push_back(32'h40900000);
    for (int i = 0; i < 9; i++) send(32'h3F000000);
    cycle();

    // clear drops the concurrent term
    cfg_terms = 4'd3;
    send(32'h3F800000);
    send(32'h3F800000);
    in_valid = 1'b1;
    in_data  = 32'h40A00000;
    clear    = 1'b1;
    cycle();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clear_cnt", {28'd0, term_cnt}, 32'd0);
    chk("clear_busy", {31'd0, busy}, 32'd0);
    exp_q.push_back(32'h40400000);
    for (int i = 0; i < 3; i++) send(32'h3F800000);
    cycle();

    // length rules
    cfg_terms = 4'd0;
    exp_q.push_back(32'hBF800000);
    send(32'hBF800000);
    cycle();
    cfg_terms = 4'd15;
    exp_q.push_back(32'h41100000);
    for (int i = 0; i < 9; i++) begin
      send(32'h3F800000);
      if (i == 8) chk("clip_valid", {31'd0, out_valid}, 32'd1);
    end
    cycle();
    cfg_terms = 4'd3;
    exp_q.push_back(32'h40400000);
    send(32'h3F800000);
    cfg_terms = 4'd1;
    send(32'h3F800000);
    chk("midcfg_cnt", {28'd0, term_cnt}, 32'd2);
    chk("midcfg_valid", {31'd0, out_valid}, 32'd0);
    send(32'h3F800000);
    chk("midcfg_done", {31'd0, out_valid}, 32'd1);
    cycle();

    // arithmetic: fractions, rounding tie, signed zero, negative result
    cfg_terms = 4'd3;
    exp_q.push_back(32'h40400000);
    send(32'h3FC00000);
    send(32'h40100000);
    send(32'hBF400000);
    cycle();
    exp_q.push_back(32'h3F800000);
    send(32'h3F800000);
    send(32'h33800000);
    send(32'h33800000);
    cycle();
    cfg_terms = 4'd1;
    exp_q.push_back(32'h80000000);
    send(32'h80000000);
    cycle();
    cfg_terms = 4'd2;
`ifdef FP_ACCUM_RELU_EN
    exp_q.push_back(32'h00000000);
`else
    exp_q.push_back(32'hC0400000);
`endif
    send(32'hBF800000);
    send(32'hC0000000);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      cycle();
      n++;
    end
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
